// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped IO peripheral on the CPU IO bus.
// Drives LEDs and an 8-digit multiplexed hex display. Returns debounced
// switches, a pending-change flag and a free-running cycle counter.
module io_bus_ctrl #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned SCAN_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [5:0] A_LED   = 6'h00;
  localparam logic [5:0] A_SEG   = 6'h01;
  localparam logic [5:0] A_SW    = 6'h02;
  localparam logic [5:0] A_STAT  = 6'h03;
  localparam logic [5:0] A_CYCLE = 6'h04;

  // Segment patterns {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [15:0]       led_q, led_d;
  logic [31:0]       seg_data_q, seg_data_d;
  logic [15:0]       sw_meta_q, sw_s_q, sw_prev_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [15:0]       sw_db_q, sw_db_d;
  logic              sw_pend_q, sw_pend_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [5:0] word_addr;
  logic       wr_led, wr_seg, wr_stat;
  logic       unused_addr_bits;

  assign word_addr        = io_addr[7:2];
  assign unused_addr_bits = ^io_addr[1:0];
  assign wr_led  = io_we && (word_addr == A_LED);
  assign wr_seg  = io_we && (word_addr == A_SEG);
  assign wr_stat = io_we && (word_addr == A_STAT);

  // Load data mux, purely combinational from the address.
  always_comb begin
    io_din = '0;
    case (word_addr)
      A_LED:   io_din = {16'h0000, led_q};
      A_SEG:   io_din = seg_data_q;
      A_SW:    io_din = {16'h0000, sw_db_q};
      A_STAT:  io_din = {31'h0, sw_pend_q};
      A_CYCLE: io_din = cycle_q;
      default: io_din = '0;
    endcase
  end

  // Next-state for registers, debouncer, cycle counter and display scan.
  always_comb begin
    led_d      = led_q;
    seg_data_d = seg_data_q;
    deb_cnt_d  = deb_cnt_q;
    sw_db_d    = sw_db_q;
    sw_pend_d  = sw_pend_q;
    cycle_d    = cycle_q + 32'd1;
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;

    if (wr_led) led_d = io_dout[15:0];
    if (wr_seg) seg_data_d = io_dout;

    if (sw_s_q != sw_prev_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
      sw_db_d = sw_s_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    // Clear first so a simultaneous new change re-sets the flag.
    if (wr_stat && io_dout[0]) sw_pend_d = 1'b0;
    if (sw_db_d != sw_db_q) sw_pend_d = 1'b1;

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end

    // Digit enable and pattern use next-state values so both stay aligned
    // with idx and a SEG write shows on the following edge.
    an_d  = ~(8'b1 << idx_d);
    seg_d = hex7(seg_data_d[{idx_d, 2'b00} +: 4]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      seg_data_q <= '0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      sw_prev_q  <= '0;
      deb_cnt_q  <= '0;
      sw_db_q    <= '0;
      sw_pend_q  <= 1'b0;
      cycle_q    <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFE;
      seg_q      <= 7'b1000000;
    end else begin
      led_q      <= led_d;
      seg_data_q <= seg_data_d;
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      sw_prev_q  <= sw_s_q;
      deb_cnt_q  <= deb_cnt_d;
      sw_db_q    <= sw_db_d;
      sw_pend_q  <= sw_pend_d;
      cycle_q    <= cycle_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign led = led_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed self-checking bench for io_bus_ctrl with SCAN_DIV=4, DEB_CYCLES=8.
module tb_io_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;

  int errors;
  int checks;

  io_bus_ctrl #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_din(io_din), .sw(sw), .led(led), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs/outputs are handled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_din;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    step();
    io_we   = 1'b0;
  endtask

  logic [7:0]  exp_an  [8];
  logic [6:0]  exp_seg [8];
  logic [31:0] d;
  int          lat;
  int          k;
  logic        seen;
  logic        glitch_ok;

  initial begin
    errors = 0;
    checks = 0;
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    rst = 1'b1; io_addr = '0; io_dout = '0; io_we = 1'b0; sw = '0;

    // 1: reset values and cycle counter
    step();
    rst = 1'b0;
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_an", {24'h0, an}, 32'hFE);
    check("rst_seg", {25'h0, seg}, 32'h40);
    rd(8'h10, d); check("cycle0", d, 32'd0);
    step(); rd(8'h10, d); check("cycle1", d, 32'd1);
    step(); rd(8'h10, d); check("cycle2", d, 32'd2);

    // 2: LED write, upper bits of io_dout ignored
    wr(8'h00, 32'h0001A5A5);
    check("led_out", {16'h0, led}, 32'h0000A5A5);
    rd(8'h00, d); check("led_rd", d, 32'h0000A5A5);

    // 3: display scan from a fresh reset, SEG written right after it
    rst = 1'b1; step(); rst = 1'b0;
    wr(8'h04, 32'h87654321);
    check("scan_an_0", {24'h0, an}, 32'hFE);
    check("scan_seg_0", {25'h0, seg}, 32'h79);
    rd(8'h04, d); check("seg_rd", d, 32'h87654321);
    for (int n = 2; n <= 33; n++) begin
      step();
      if (n % 4 == 1) begin
        k = (n / 4) % 8;
        check($sformatf("scan_an_n%0d", n), {24'h0, an}, {24'h0, exp_an[k]});
        check($sformatf("scan_seg_n%0d", n), {25'h0, seg}, {25'h0, exp_seg[k]});
      end
    end
    // mid-digit SEG write changes the pattern on the next edge, digit unchanged
    wr(8'h04, 32'h8765432F);
    check("segwr_an", {24'h0, an}, 32'hFE);
    check("segwr_seg", {25'h0, seg}, 32'h0E);

    // 4: debounce acceptance latency and pending flag
    sw = 16'h00F0;
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      rd(8'h08, d);
      if (!seen && d == 32'h000000F0) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check("deb_seen", {31'h0, seen}, 32'h1);
    check("deb_lat_in_range", {31'h0, (lat >= 10 && lat <= 12)}, 32'h1);
    rd(8'h0C, d); check("pend_set", d, 32'h1);
    wr(8'h0C, 32'h0);
    rd(8'h0C, d); check("pend_w0_keeps", d, 32'h1);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d); check("pend_w1c", d, 32'h0);
    // short glitch must not be accepted
    sw = 16'h0F0F;
    step(); step(); step();
    sw = 16'h00F0;
    glitch_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      rd(8'h08, d);
      if (d != 32'h000000F0) glitch_ok = 1'b0;
    end
    check("glitch_sw_db", {31'h0, glitch_ok}, 32'h1);
    rd(8'h0C, d); check("glitch_pend", d, 32'h0);
    wr(8'h08, 32'hFFFFFFFF);
    rd(8'h08, d); check("sw_ro", d, 32'h000000F0);

    // 5: W1C on the same edge that sw_db changes: set wins
    sw = 16'h1234;
    for (int i = 1; i < lat; i++) step();
    rd(8'h08, d); check("pre_change_sw", d, 32'h000000F0);
    wr(8'h0C, 32'h1);
    rd(8'h08, d); check("race_sw_db", d, 32'h00001234);
    rd(8'h0C, d); check("race_pend", d, 32'h1);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d); check("pend_clear2", d, 32'h0);

    // 6: reset mid-scan and mid-debounce, write during reset ignored
    wr(8'h00, 32'h0000FFFF);
    wr(8'h04, 32'hFFFFFFFF);
    sw = 16'hAAAA;
    step(); step(); step(); step(); step();
    rst = 1'b1;
    io_addr = 8'h00; io_dout = 32'h00001234; io_we = 1'b1;
    step();
    rst = 1'b0; io_we = 1'b0;
    check("rst2_led", {16'h0, led}, 32'h0);
    check("rst2_an", {24'h0, an}, 32'hFE);
    check("rst2_seg", {25'h0, seg}, 32'h40);
    rd(8'h10, d); check("rst2_cycle", d, 32'h0);
    rd(8'h08, d); check("rst2_sw", d, 32'h0);
    rd(8'h0C, d); check("rst2_pend", d, 32'h0);
    rd(8'h04, d); check("rst2_segdata", d, 32'h0);
    rd(8'h3C, d); check("unmapped_rd", d, 32'h0);
    wr(8'h3C, 32'hFFFFFFFF);
    check("unmapped_wr_led", {16'h0, led}, 32'h0);
    rd(8'h04, d); check("unmapped_wr_seg", d, 32'h0);
    rd(8'h00, d); check("unmapped_wr_ledrd", d, 32'h0);
    // debouncer restarts from scratch after reset and still accepts
    for (int i = 0; i < 14; i++) step();
    rd(8'h08, d); check("post_rst_deb", d, 32'h0000AAAA);
    rd(8'h0C, d); check("post_rst_pend", d, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
